// File: rtl/jk_drv_pkg.sv
// Shared types and per-bit JK excitation for the JK bank driver.
// JK_TOGGLE_PREF_EN selects toggle-preferred excitation instead of hold-preferred.
package jk_drv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    CHECK,
    DONE,
    ERR
  } state_e;

  // Returns {j, k} that moves one flop from q to t.
  function automatic logic [1:0] excite(input logic q, input logic t);
`ifdef JK_TOGGLE_PREF_EN
    return {t | q, ~t | ~q};
`else
    return {t & ~q, ~t & q};
`endif
  endfunction

endpackage

// File: rtl/jk_excite.sv
// Combinational WIDTH-bit JK excitation from current state q_i to target t_i.
// Equations follow jk_drv_pkg::excite (JK_TOGGLE_PREF_EN selects the variant).
module jk_excite
  import jk_drv_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] t_i,
  output logic [WIDTH-1:0] j_o,
  output logic [WIDTH-1:0] k_o
);

  always_comb begin
    j_o = '0;
    k_o = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      {j_o[i], k_o[i]} = excite(q_i[i], t_i[i]);
    end
  end

endmodule

// File: rtl/jk_bank_driver.sv
// Drives a JK flop bank to a requested pattern, verifies via q_fb and retries.
// JK_TOGGLE_PREF_EN (see jk_drv_pkg) changes only the j/k values, not the bank result.
module jk_bank_driver
  import jk_drv_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] tgt,
  input  logic             tgt_valid,
  output logic             tgt_ready,
  input  logic             abort,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             done,
  output logic             err
);

  localparam int unsigned  CW        = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [CW-1:0] RETRY_LIM = CW'(MAX_RETRY);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] tgt_q, tgt_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] j_q, j_d;
  logic [WIDTH-1:0] k_q, k_d;

  logic [WIDTH-1:0] exc_t, exc_j, exc_k;

  // From IDLE the target is latched on the same edge, so excite from the live input.
  assign exc_t = (state_q == IDLE) ? tgt : tgt_q;

  jk_excite #(
    .WIDTH(WIDTH)
  ) u_excite (
    .q_i(q_fb),
    .t_i(exc_t),
    .j_o(exc_j),
    .k_o(exc_k)
  );

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    j_d     = '0;
    k_d     = '0;
    case (state_q)
      IDLE: begin
        if (tgt_valid) begin
          tgt_d   = tgt;
          cnt_d   = '0;
          state_d = DRIVE;
          j_d     = exc_j;
          k_d     = exc_k;
        end
      end
      DRIVE: begin
        state_d = abort ? IDLE : CHECK;
      end
      CHECK: begin
        if (abort) begin
          state_d = IDLE;
        end else if (q_fb == tgt_q) begin
          state_d = DONE;
        end else if (cnt_q < RETRY_LIM) begin
          cnt_d   = cnt_q + 1'b1;
          state_d = DRIVE;
          j_d     = exc_j;
          k_d     = exc_k;
        end else begin
          state_d = ERR;
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      tgt_q   <= '0;
      cnt_q   <= '0;
      j_q     <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
      j_q     <= j_d;
      k_q     <= k_d;
    end
  end

  assign j         = j_q;
  assign k         = k_q;
  assign tgt_ready = (state_q == IDLE);
  assign done      = (state_q == DONE);
  assign err       = (state_q == ERR);

endmodule

// File: tb/tb_jk_bank_driver.sv
// Self-checking bench: behavioural 4-bit JK bank on q_fb, scoreboard of expected outcomes.
module tb_jk_bank_driver;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] tgt;
  logic       tgt_valid;
  logic       tgt_ready;
  logic       abort;
  logic [3:0] q_fb;
  logic [3:0] j, k;
  logic       done, err;

  always #5 clk = ~clk;

  jk_bank_driver #(
    .WIDTH(4),
    .MAX_RETRY(3)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .tgt      (tgt),
    .tgt_valid(tgt_valid),
    .tgt_ready(tgt_ready),
    .abort    (abort),
    .q_fb     (q_fb),
    .j        (j),
    .k        (k),
    .done     (done),
    .err      (err)
  );

  // Bank model: ign_tok != ign_used makes it ignore the next non-zero drive;
  // mask bits are permanently stuck.
  logic [3:0] bank = 4'b0000;
  logic [3:0] mask = 4'b0000;
  int         ign_tok = 0;
  int         ign_used = 0;

  assign q_fb = bank;

  always @(posedge clk) begin
    if (((j | k) != 4'b0000) && (ign_tok != ign_used)) begin
      ign_used <= ign_used + 1;
    end else begin
      bank <= (((j & ~bank) | (~k & bank)) & ~mask) | (bank & mask);
    end
  end

  function automatic logic [7:0] exp_jk(input logic [3:0] q, input logic [3:0] t);
`ifdef JK_TOGGLE_PREF_EN
    return {t | q, ~t | ~q};
`else
    return {t & ~q, ~t & q};
`endif
  endfunction

  typedef struct {
    bit is_err;
    int lat;
  } exp_t;
  exp_t sb[$];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_vec++;
    if (got !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, expv);
    end
  endtask

  task automatic run_txn(input logic [3:0] t, input logic [3:0] ej, input logic [3:0] ek,
                         input bit is_err, input int drives, input bit hold);
    exp_t       e;
    exp_t       got_e;
    int         cyc;
    bit         seen;
    logic [7:0] ex;
    e.is_err = is_err;
    e.lat    = 2 * drives + 1;
    sb.push_back(e);
    @(negedge clk);
    tgt       = t;
    tgt_valid = 1'b1;
    check("ready_idle", tgt_ready, 1);
    @(posedge clk);
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (hold) tgt = ~t;
      else tgt_valid = 1'b0;
      if (cyc == 1) begin
        check("ready_busy", tgt_ready, 0);
        check("j_first", j, ej);
        check("k_first", k, ek);
      end
      if (done || err) begin
        seen      = 1'b1;
        tgt_valid = 1'b0;
        check("done_err_excl", done & err, 0);
      end else if ((cyc % 2 == 1) && (cyc <= 2 * drives - 1)) begin
        ex = exp_jk(bank, t);
        check("j_drive", j, ex[7:4]);
        check("k_drive", k, ex[3:0]);
      end else if (cyc % 2 == 0) begin
        check("jk_clear", j | k, 0);
      end
    end
    check("outcome_seen", seen, 1);
    got_e = sb.pop_front();
    if (seen) begin
      check("kind", err, got_e.is_err);
      check("latency", cyc, got_e.lat);
    end
  endtask

`ifdef JK_TOGGLE_PREF_EN
  localparam logic [3:0] J2 = 4'b1010, K2 = 4'b1111;
  localparam logic [3:0] J3 = 4'b1111, K3 = 4'b1111;
  localparam logic [3:0] J4 = 4'b1111, K4 = 4'b1010;
  localparam logic [3:0] J5 = 4'b1111, K5 = 4'b1111;
`else
  localparam logic [3:0] J2 = 4'b1010, K2 = 4'b0000;
  localparam logic [3:0] J3 = 4'b0101, K3 = 4'b1010;
  localparam logic [3:0] J4 = 4'b1010, K4 = 4'b0000;
  localparam logic [3:0] J5 = 4'b0000, K5 = 4'b1111;
`endif

  initial begin
    logic [7:0] ex;
    reset     = 1'b0;
    tgt       = 4'b0000;
    tgt_valid = 1'b0;
    abort     = 1'b0;

    // Reset state, held over several cycles
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_j", j, 0);
      check("rst_k", k, 0);
      check("rst_ready", tgt_ready, 1);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
    end
    @(negedge clk);
    reset = 1'b1;

    run_txn(4'b1010, J2, K2, 1'b0, 1, 1'b0);
    check("bank_1010", bank, 4'b1010);

    run_txn(4'b0101, J3, K3, 1'b0, 1, 1'b0);
    check("bank_0101", bank, 4'b0101);

    // First drive ignored by the bank: one retry
    ign_tok = ign_tok + 1;
    run_txn(4'b1111, J4, K4, 1'b0, 2, 1'b0);
    check("bank_1111", bank, 4'b1111);

    // Bit 0 permanently stuck at 1: retries exhausted
    mask = 4'b0001;
    run_txn(4'b0000, J5, K5, 1'b1, 4, 1'b0);
    check("bank_stuck", bank, 4'b0001);
    mask = 4'b0000;

    // Abort in CHECK with a match present, then abort-in-IDLE accept
    @(negedge clk);
    tgt       = 4'b0001;
    tgt_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tgt_valid = 1'b0;
    @(negedge clk);
    abort = 1'b1;
    check("abort_chk_done", done, 0);
    @(negedge clk);
    check("abort_idle_ready", tgt_ready, 1);
    check("abort_no_done", done, 0);
    check("abort_no_err", err, 0);
    check("abort_jk", j | k, 0);
    tgt       = 4'b0110;
    tgt_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    abort     = 1'b0;
    tgt_valid = 1'b0;
    ex = exp_jk(bank, 4'b0110);
    check("abort_accept", tgt_ready, 0);
    check("abort_new_j", j, ex[7:4]);
    check("abort_new_k", k, ex[3:0]);
    @(negedge clk);
    @(negedge clk);
    check("abort_new_done", done, 1);
    check("bank_0110", bank, 4'b0110);

    // Reset asserted mid-DRIVE
    @(negedge clk);
    tgt       = 4'b1001;
    tgt_valid = 1'b1;
    @(posedge clk);
    #2;
    ex = exp_jk(bank, 4'b1001);
    check("pre_rst_j", j, ex[7:4]);
    reset     = 1'b0;
    tgt_valid = 1'b0;
    #1;
    check("async_rst_j", j, 0);
    check("async_rst_k", k, 0);
    check("async_rst_ready", tgt_ready, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_no_pulse", done | err, 0);
    end
    reset = 1'b1;
    check("bank_held", bank, 4'b0110);

    // tgt_valid held while busy: later targets ignored
    ex = exp_jk(bank, 4'b1001);
    run_txn(4'b1001, ex[7:4], ex[3:0], 1'b0, 1, 1'b1);
    check("bank_1001", bank, 4'b1001);
    @(negedge clk);
    check("idle_after_hold", tgt_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
